imem_fetch_queue: RTL
=====================

Name: imem_fetch_queue

Overview:
Instruction-fetch front end directly upstream of the core's IF stage. Accepts the next fetch PC from the core, issues pipelined read requests to instruction memory, and tags returning data with PC and status in a small in-order queue. Presents one parcel at a time on the core's if_parcel* inputs. Handles core stall, flush (in-flight responses discarded), and backpressure via if_stall_nxt_pc.

Parameters:
XLEN, 32, address/PC width
PARCEL_SIZE, 32, parcel width in bits; fetch granularity equals PARCEL_SIZE
DEPTH, 4, queue entries and maximum outstanding requests; power of 2, at least 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_nxt_pc  in  XLEN  next fetch PC from core
if_stall_nxt_pc  out  1  1 = if_nxt_pc not accepted this cycle
if_stall  in  1  core not consuming the head parcel
if_flush  in  1  discard queue and in-flight fetches
if_parcel  out  PARCEL_SIZE  head parcel
if_parcel_pc  out  XLEN  PC of head parcel
if_parcel_valid  out  PARCEL_SIZE/16  all-ones when head valid, else 0
if_parcel_misaligned  out  1  head PC not PARCEL_SIZE/8-aligned
if_parcel_page_fault  out  1  head fetch returned bus error
imem_req  out  1  read request
imem_adr  out  XLEN  request address, low log2(PARCEL_SIZE/8) bits forced to 0
imem_stall  in  1  bus cannot accept request this cycle
imem_ack  in  1  response valid, in request order, latency >= 1
imem_err  in  1  response error, qualified by imem_ack
imem_q  in  PARCEL_SIZE  response data

Behaviour:
- Reset: imem_req=0, imem_adr=0, if_parcel_valid=0, if_parcel=0, if_parcel_pc=0, both flags 0, if_stall_nxt_pc=1 during rst; all counters and pointers 0.
- Credit: issue allowed when outstanding + occupancy < DEPTH, !if_flush, and no discards pending. if_stall_nxt_pc = !(issue allowed) | imem_stall.
- Issue: combinational imem_req = issue allowed; imem_adr from if_nxt_pc, aligned. Accepted when imem_req & !imem_stall; on acceptance the PC and misaligned bit (if_nxt_pc low bits != 0) are pushed to a DEPTH-entry tag FIFO and outstanding increments.
- Response: on imem_ack with discard = 0, pop tag FIFO, push {imem_q, pc, misaligned, imem_err} to the data queue, and decrement outstanding. The credit rule guarantees the queue never overflows; a push into a full queue is a design error (assertion).
- Output: head entry is driven from registered storage. if_parcel_valid is all-ones when non-empty. Pop when valid & !if_stall. Zero-latency pass-through is not supported: earliest parcel is 1 cycle after imem_ack.
- Simultaneous push and pop on a full queue: both occur and occupancy is unchanged.
- Flush: in the if_flush cycle the data queue and tag FIFO are emptied. discard := outstanding minus (1 if imem_ack this cycle). No issue occurs in the flush cycle. Subsequent acks with discard > 0 are dropped and decrement discard. Issue resumes when discard = 0. if_parcel_valid = 0 in the cycle after flush.
- Flush with discard > 0 already pending: discard is recomputed from outstanding, with the same rule.
- Counters are sized log2(DEPTH)+1 bits and never wrap. Pointers wrap modulo DEPTH.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_starve_cnt (32 bits: cycles where !if_stall and queue empty and no flush) and perf_discard_cnt (32 bits: responses dropped after flush). Both saturate at all-ones and reset to 0. When undefined, these ports and their logic are absent.

Test Plan:
- Reset then if_nxt_pc=0x200, bus latency 1, if_stall=0 -> imem_adr=0x200 same cycle; parcel 0x00000013 valid with pc 0x200 two cycles after issue.
- Bus latency 5 with continuous requests -> exactly 4 outstanding; if_stall_nxt_pc=1 until the first ack; ordering preserved with pcs 0x200, 0x204, 0x208, 0x20C.
- if_stall=1 for 10 cycles, latency 1 -> queue fills to 4 and issue stops; releasing the stall delivers 4 parcels on consecutive cycles with no loss.
- 3 outstanding, if_flush with an ack in the same cycle -> discard=2; the next 2 acks are dropped; the next if_nxt_pc=0x400 is issued after the last drop and is the first parcel seen.
- imem_err=1 on the response for 0x300 -> head shows page_fault=1 for pc 0x300 only; if_nxt_pc=0x302 -> imem_adr=0x300, misaligned=1.
- rst asserted mid-burst with 2 outstanding -> all outputs zero immediately (asynchronous); late acks after release with outstanding=0 are flagged by assertion and not enqueued.

Source files
------------

// File: rtl/imem_fetch_queue_if.sv
// Core-side and instruction-memory-side signal bundle for imem_fetch_queue.
// master = fetch queue view, slave = core/memory environment view.
interface imem_fetch_queue_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32
);
  logic [XLEN-1:0]          if_nxt_pc;
  logic                     if_stall_nxt_pc;
  logic                     if_stall;
  logic                     if_flush;
  logic [PARCEL_SIZE-1:0]   if_parcel;
  logic [XLEN-1:0]          if_parcel_pc;
  logic [PARCEL_SIZE/16-1:0] if_parcel_valid;
  logic                     if_parcel_misaligned;
  logic                     if_parcel_page_fault;

  logic                     imem_req;
  logic [XLEN-1:0]          imem_adr;
  logic                     imem_stall;
  logic                     imem_ack;
  logic                     imem_err;
  logic [PARCEL_SIZE-1:0]   imem_q;

  modport master (
    input  if_nxt_pc, if_stall, if_flush,
    input  imem_stall, imem_ack, imem_err, imem_q,
    output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
    output if_parcel_misaligned, if_parcel_page_fault,
    output imem_req, imem_adr
  );

  modport slave (
    output if_nxt_pc, if_stall, if_flush,
    output imem_stall, imem_ack, imem_err, imem_q,
    input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
    input  if_parcel_misaligned, if_parcel_page_fault,
    input  imem_req, imem_adr
  );
endinterface

// File: rtl/imem_fetch_queue.sv
// Pipelined instruction fetch queue: issues aligned reads, tags responses in order, presents one parcel.
// Define FETCH_PERF_CNT_EN to add the saturating perf_starve_cnt / perf_discard_cnt outputs.
module imem_fetch_queue #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_starve_cnt,
  output logic [31:0] perf_discard_cnt,
`endif
  imem_fetch_queue_if.master fq
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int OFFW = $clog2(PARCEL_SIZE / 8);
  localparam int NV   = PARCEL_SIZE / 16;

  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [CW-1:0] r_outstanding, r_count, r_discard;
  logic [CW-1:0] w_outstanding_next, w_count_next, w_discard_next;
  logic [AW-1:0] r_tag_wptr, r_tag_rptr, r_dq_wptr, r_dq_rptr;
  logic [AW-1:0] w_tag_wptr_next, w_tag_rptr_next, w_dq_wptr_next, w_dq_rptr_next;

  logic [XLEN-1:0]        r_tag_pc  [DEPTH];
  logic                   r_tag_mis [DEPTH];
  logic [PARCEL_SIZE-1:0] r_dq_data [DEPTH];
  logic [XLEN-1:0]        r_dq_pc   [DEPTH];
  logic                   r_dq_mis  [DEPTH];
  logic                   r_dq_err  [DEPTH];

  logic [CW:0]     w_credit_used;
  logic            w_issue_ok;
  logic            w_accept;
  logic            w_ack_any;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic            w_misaligned;
  logic [XLEN-1:0] w_adr_aligned;

  // r_outstanding counts every in-flight request; r_discard is the subset to be dropped.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_issue_ok    = !rst && (w_credit_used < DEPTH_SUM) && !fq.if_flush && (r_discard == '0);
  assign w_accept      = w_issue_ok && !fq.imem_stall;
  assign w_ack_any     = fq.imem_ack && (r_outstanding != '0);
  assign w_drop        = w_ack_any && (fq.if_flush || (r_discard != '0));
  assign w_push        = w_ack_any && !w_drop;
  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && !fq.if_stall && !fq.if_flush;

  assign w_misaligned  = (fq.if_nxt_pc[OFFW-1:0] != '0);
  assign w_adr_aligned = {fq.if_nxt_pc[XLEN-1:OFFW], {OFFW{1'b0}}};

  always_comb begin
    w_outstanding_next = r_outstanding;
    w_discard_next     = r_discard;
    w_count_next       = r_count;
    w_tag_wptr_next    = r_tag_wptr;
    w_tag_rptr_next    = r_tag_rptr;
    w_dq_wptr_next     = r_dq_wptr;
    w_dq_rptr_next     = r_dq_rptr;

    if (fq.if_flush) begin
      // An ack landing in the flush cycle is consumed here, so it is not counted as a discard.
      w_outstanding_next = r_outstanding - (w_ack_any ? ONE : '0);
      w_discard_next     = w_outstanding_next;
      w_count_next       = '0;
      w_tag_wptr_next    = '0;
      w_tag_rptr_next    = '0;
      w_dq_wptr_next     = '0;
      w_dq_rptr_next     = '0;
    end else begin
      case ({w_accept, w_ack_any})
        2'b10:   w_outstanding_next = r_outstanding + ONE;
        2'b01:   w_outstanding_next = r_outstanding - ONE;
        default: w_outstanding_next = r_outstanding;
      endcase

      if (w_drop) begin
        w_discard_next = r_discard - ONE;
      end
      if (w_accept) begin
        w_tag_wptr_next = r_tag_wptr + PTR_ONE;
      end
      if (w_push) begin
        w_tag_rptr_next = r_tag_rptr + PTR_ONE;
        w_dq_wptr_next  = r_dq_wptr + PTR_ONE;
      end
      if (w_pop) begin
        w_dq_rptr_next = r_dq_rptr + PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + ONE;
        2'b01:   w_count_next = r_count - ONE;
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_dq_wptr     <= '0;
      r_dq_rptr     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      r_count       <= w_count_next;
      r_tag_wptr    <= w_tag_wptr_next;
      r_tag_rptr    <= w_tag_rptr_next;
      r_dq_wptr     <= w_dq_wptr_next;
      r_dq_rptr     <= w_dq_rptr_next;
    end
  end

  // Payload storage carries no reset; the head outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_pc[r_tag_wptr]  <= fq.if_nxt_pc;
      r_tag_mis[r_tag_wptr] <= w_misaligned;
    end
    if (w_push) begin
      r_dq_data[r_dq_wptr] <= fq.imem_q;
      r_dq_pc[r_dq_wptr]   <= r_tag_pc[r_tag_rptr];
      r_dq_mis[r_dq_wptr]  <= r_tag_mis[r_tag_rptr];
      r_dq_err[r_dq_wptr]  <= fq.imem_err;
    end
  end

  assign fq.imem_req             = w_issue_ok;
  assign fq.imem_adr             = rst ? '0 : w_adr_aligned;
  assign fq.if_stall_nxt_pc      = !w_issue_ok || fq.imem_stall;
  assign fq.if_parcel_valid      = {NV{w_valid}};
  assign fq.if_parcel            = w_valid ? r_dq_data[r_dq_rptr] : '0;
  assign fq.if_parcel_pc         = w_valid ? r_dq_pc[r_dq_rptr]   : '0;
  assign fq.if_parcel_misaligned = w_valid && r_dq_mis[r_dq_rptr];
  assign fq.if_parcel_page_fault = w_valid && r_dq_err[r_dq_rptr];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_starve_cnt;
  logic [31:0] r_discard_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt  <= '0;
      r_discard_cnt <= '0;
    end else begin
      if (!fq.if_stall && !w_valid && !fq.if_flush && (r_starve_cnt != '1)) begin
        r_starve_cnt <= r_starve_cnt + 32'd1;
      end
      if (w_drop && (r_discard_cnt != '1)) begin
        r_discard_cnt <= r_discard_cnt + 32'd1;
      end
    end
  end

  assign perf_starve_cnt  = r_starve_cnt;
  assign perf_discard_cnt = r_discard_cnt;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == DEPTH_CNT)));

  // An ack with nothing in flight is a bus protocol error; it is ignored, never enqueued.
  a_no_spurious_ack: assert property (@(posedge clk) disable iff (rst)
    !(fq.imem_ack && (r_outstanding == '0)));

endmodule
